// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEFAULT_ADDR_WIDTH = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream into the loader plus the instruction-memory write port it drives.
// slave = loader side, master = sender / memory side.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word; word_full flags
// the accept that completes the word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] byte_idx;

  assign word_full = accept && (byte_idx == 2'(BYTES_PER_WORD - 1));

  // The index wraps 3 -> 0 on its own, so the next word always starts at lane 0.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      word[{byte_idx, 3'b000} +: 8] <= byte_in;
      byte_idx                      <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory one word per write and
// holds the core in reset until the whole program has landed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
)(
  input  logic                clock,
  input  logic                reset_,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                core_reset_,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  loader_state_e         state, state_next;
  logic                  accept;
  logic                  word_full;
  logic                  load_start;
  logic                  last_seen;
  logic                  at_top;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           packed_word;

  // in_ready is decoded from state only, so there is no path from in_valid.
  assign bus.in_ready = (state == ST_COLLECT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign at_top       = (wr_addr == {ADDR_WIDTH{1'b1}});
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = packed_word;

  imem_loader_byte_packer u_packer (
    .clock     (clock),
    .reset_    (reset_),
    .clear     (load_start),
    .accept    (accept),
    .byte_in   (bus.in_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_comb begin
    state_next = state;
    load_start = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next = ST_COLLECT;
          load_start = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          if (word_full)        state_next = ST_WRITE;
          else if (bus.in_last) state_next = ST_ERROR;
        end
      end
      ST_WRITE: begin
        if (last_seen)   state_next = ST_DONE;
        else if (at_top) state_next = ST_ERROR;
        else             state_next = ST_COLLECT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up exactly
  // with the state they describe (core_reset_ rises on the first DONE cycle).
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state        <= ST_IDLE;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      words_loaded <= '0;
      last_seen    <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      core_reset_  <= 1'b0;
    end else begin
      state       <= state_next;
      wr_en       <= (state_next == ST_WRITE);
      done        <= (state_next == ST_DONE);
      core_reset_ <= (state_next == ST_DONE);
      error       <= (state_next == ST_ERROR);
      if (load_start) begin
        wr_addr      <= '0;
        words_loaded <= '0;
        last_seen    <= 1'b0;
      end
      if (accept && word_full) last_seen <= bus.in_last;
      if (state == ST_WRITE) begin
        words_loaded <= words_loaded + 1'b1;
        if (!last_seen && !at_top) wr_addr <= wr_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, stalled, misaligned, overflow,
// reload and mid-load reset scenarios with hand-computed expected writes.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset_;
  logic          start;
  logic          core_reset_;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset_       (reset_),
    .start        (start),
    .bus          (bus),
    .core_reset_  (core_reset_),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wr_addr_log[$];
  logic [31:0]   wr_data_log[$];
  int            ready_viol;
  int            cyc = 0;
  int            last_wr_cyc;
  int            rise_cyc;
  logic          prev_core_reset = 1'b0;

  // Write monitor sampled just after each rising edge.
  always begin
    @(posedge clock);
    #1;
    cyc++;
    if (bus.wr_en) begin
      wr_addr_log.push_back(bus.wr_addr);
      wr_data_log.push_back(bus.wr_data);
      last_wr_cyc = cyc;
      if (bus.in_ready) ready_viol++;
    end
    if (core_reset_ && !prev_core_reset) rise_cyc = cyc;
    prev_core_reset = core_reset_;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Offer one byte; optional random bubbles on in_valid. Data is held while in_ready is low.
  task automatic applyStimulus(input logic [7:0] b, input logic last, input bit stalls);
    bit sent  = 1'b0;
    int guard = 0;
    while (!sent) begin
      @(negedge clock);
      if (stalls && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        if (bus.in_ready) sent = 1'b1;
      end
      guard++;
      if (!sent && guard > 50) begin
        checkOutput("send_timeout", 32'd0, 32'd1);
        sent = 1'b1;
      end
    end
  endtask

  task automatic idleBus();
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic clearLog();
    wr_addr_log.delete();
    wr_data_log.delete();
    ready_viol = 0;
  endtask

  task automatic waitDoneOrError(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!(done || error)) checkOutput("finish_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendProgram(input bit stalls);
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    for (int i = 0; i < 8; i++) applyStimulus(prog[i], (i == 7), stalls);
    idleBus();
  endtask

  task automatic checkProgram(input string tag);
    checkOutput({tag, "_nwr"}, 32'(wr_addr_log.size()), 32'd2);
    if (wr_addr_log.size() == 2) begin
      checkOutput({tag, "_a0"}, 32'(wr_addr_log[0]), 32'd0);
      checkOutput({tag, "_d0"}, wr_data_log[0], 32'h0000_0013);
      checkOutput({tag, "_a1"}, 32'(wr_addr_log[1]), 32'd1);
      checkOutput({tag, "_d1"}, wr_data_log[1], 32'h0050_0093);
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_words"}, 32'(words_loaded), 32'd2);
    checkOutput({tag, "_core_rst"}, 32'(core_reset_), 32'd1);
    checkOutput({tag, "_rise_lat"}, 32'(rise_cyc - last_wr_cyc), 32'd1);
    checkOutput({tag, "_ready_in_wr"}, 32'(ready_viol), 32'd0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_core_rst"}, 32'(core_reset_), 32'd0);
    checkOutput({tag, "_words"}, 32'(words_loaded), 32'd0);
    checkOutput({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
    checkOutput({tag, "_data"}, bus.wr_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_word;

    reset_       = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    ready_viol   = 0;
    last_wr_cyc  = 0;
    rise_cyc     = -100;
    repeat (3) @(negedge clock);
    checkIdle("reset");
    reset_ = 1'b1;

    // Clean two-word program.
    $display("[TB] two-word load, no stalls");
    pulseStart();
    checkOutput("start_ready", 32'(bus.in_ready), 32'd1);
    clearLog();
    sendProgram(1'b0);
    waitDoneOrError(20);
    checkProgram("plain");

    // Reload from DONE with random bubbles; done/core_reset_ drop with COLLECT entry.
    $display("[TB] reload with stalls");
    pulseStart();
    checkOutput("reload_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reload_done", 32'(done), 32'd0);
    checkOutput("reload_core_rst", 32'(core_reset_), 32'd0);
    clearLog();
    sendProgram(1'b1);
    waitDoneOrError(100);
    checkProgram("stall");

    // in_last on 6th byte: only the first word is written.
    $display("[TB] misaligned last");
    pulseStart();
    clearLog();
    for (int i = 0; i < 6; i++) applyStimulus(8'(i + 1), (i == 5), 1'b0);
    idleBus();
    waitDoneOrError(20);
    repeat (2) @(negedge clock);
    checkOutput("mis_nwr", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() >= 1) begin
      checkOutput("mis_a0", 32'(wr_addr_log[0]), 32'd0);
      checkOutput("mis_d0", wr_data_log[0], 32'h0403_0201);
    end
    checkOutput("mis_error", 32'(error), 32'd1);
    checkOutput("mis_done", 32'(done), 32'd0);
    checkOutput("mis_core_rst", 32'(core_reset_), 32'd0);
    checkOutput("mis_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("mis_words", 32'(words_loaded), 32'd1);
    pulseStart();
    checkOutput("mis_restart_error", 32'(error), 32'd0);
    checkOutput("mis_restart_ready", 32'(bus.in_ready), 32'd1);

    // 256 bytes with no in_last overflow the 64-word memory.
    $display("[TB] overflow");
    clearLog();
    for (int i = 0; i < 256; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    idleBus();
    waitDoneOrError(20);
    checkOutput("ovf_nwr", 32'(wr_addr_log.size()), 32'd64);
    if (wr_addr_log.size() == 64) begin
      for (int w = 0; w < 64; w++) begin
        b0 = 8'(4 * w);
        b1 = 8'(4 * w + 1);
        b2 = 8'(4 * w + 2);
        b3 = 8'(4 * w + 3);
        exp_word = {b3, b2, b1, b0};
        checkOutput($sformatf("ovf_a%0d", w), 32'(wr_addr_log[w]), 32'(w));
        checkOutput($sformatf("ovf_d%0d", w), wr_data_log[w], exp_word);
      end
    end
    checkOutput("ovf_error", 32'(error), 32'd1);
    checkOutput("ovf_words", 32'(words_loaded), 32'd64);
    checkOutput("ovf_core_rst", 32'(core_reset_), 32'd0);
    checkOutput("ovf_ready", 32'(bus.in_ready), 32'd0);

    // Complete a one-word load, then reload with AA BB CC DD.
    $display("[TB] reload after completed load");
    pulseStart();
    clearLog();
    applyStimulus(8'h11, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b0);
    applyStimulus(8'h44, 1'b1, 1'b0);
    idleBus();
    waitDoneOrError(20);
    checkOutput("pre_done", 32'(done), 32'd1);
    checkOutput("pre_core_rst", 32'(core_reset_), 32'd1);
    pulseStart();
    checkOutput("re_done", 32'(done), 32'd0);
    checkOutput("re_core_rst", 32'(core_reset_), 32'd0);
    checkOutput("re_ready", 32'(bus.in_ready), 32'd1);
    clearLog();
    applyStimulus(8'hAA, 1'b0, 1'b0);
    applyStimulus(8'hBB, 1'b0, 1'b0);
    applyStimulus(8'hCC, 1'b0, 1'b0);
    applyStimulus(8'hDD, 1'b1, 1'b0);
    idleBus();
    waitDoneOrError(20);
    checkOutput("re_nwr", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() >= 1) begin
      checkOutput("re_a0", 32'(wr_addr_log[0]), 32'd0);
      checkOutput("re_d0", wr_data_log[0], 32'hDDCC_BBAA);
    end
    checkOutput("re_final_done", 32'(done), 32'd1);
    checkOutput("re_words", 32'(words_loaded), 32'd1);

    // Reset mid-load after two bytes; the next load restarts at lane 0, address 0.
    $display("[TB] reset mid-load");
    pulseStart();
    clearLog();
    applyStimulus(8'h55, 1'b0, 1'b0);
    applyStimulus(8'h66, 1'b0, 1'b0);
    idleBus();
    reset_ = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;
    checkIdle("mid_rst");
    checkOutput("mid_rst_nwr", 32'(wr_addr_log.size()), 32'd0);
    pulseStart();
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    applyStimulus(8'h04, 1'b1, 1'b0);
    idleBus();
    waitDoneOrError(20);
    checkOutput("post_rst_nwr", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() >= 1) begin
      checkOutput("post_rst_a0", 32'(wr_addr_log[0]), 32'd0);
      checkOutput("post_rst_d0", wr_data_log[0], 32'h0403_0201);
    end
    checkOutput("post_rst_done", 32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the instruction memory and the core. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words and issues one write per word into the instruction memory's write port. It holds the core in reset until the full program has been written, then releases it.

## Interface
- ADDR_WIDTH, 6, word-address width of instruction memory (depth 2^ADDR_WIDTH = 64 words)
- clock  in  1  single system clock, all logic on posedge
- reset_  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a (re)load
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_last  in  1  marks final byte of program; qualified by in_valid
- in_ready  out  1  loader accepts byte this cycle
- wr_en  out  1  instruction-memory write strobe
- wr_addr  out  ADDR_WIDTH  word address of write
- wr_data  out  32  instruction word
- core_reset_  out  1  active-low reset to core; 1 only when load is complete
- done  out  1  program loaded successfully
- error  out  1  load aborted (misaligned last or overflow)
- words_loaded  out  ADDR_WIDTH+1  number of words written in current/last load

## Operation
- States: IDLE, COLLECT, WRITE, DONE, ERROR.
- Reset: state IDLE; in_ready, wr_en, done, error, core_reset_ = 0; wr_addr, wr_data, words_loaded, byte index = 0.
- IDLE: start -> COLLECT, clear wr_addr, byte index, words_loaded, error.
- COLLECT: in_ready = 1. Transfer occurs when in_valid & in_ready. Byte k (k = 0..3) lands in wr_data[8k+7:8k]. On byte 3 -> WRITE; remember in_last.
- in_last on byte index 0..2 -> ERROR (partial word is not written).
- WRITE (exactly one cycle): wr_en = 1, in_ready = 0; words_loaded increments. Next: last seen -> DONE; else wr_addr = 2^ADDR_WIDTH-1 -> ERROR (overflow); else wr_addr+1, byte index 0 -> COLLECT.
- DONE: done = 1, core_reset_ = 1. start -> COLLECT (reload); core_reset_ and done drop to 0 in the same cycle COLLECT is entered.
- ERROR: error = 1, core_reset_ = 0, in_ready = 0. Only start leaves it (-> COLLECT, error cleared).
- start is ignored in COLLECT and WRITE.
- wr_addr/wr_data stable whenever wr_en = 1; unchanged outside WRITE except as above.

## Timing
- All outputs registered except in_ready, which is decoded from state (no combinational path from in_valid).
- Byte-to-write latency: wr_en asserted the cycle after byte 3 is accepted.
- Throughput: 4 bytes per 5 cycles maximum (in_ready low during WRITE).
- core_reset_ rises in the first cycle in DONE, i.e. the cycle after the final wr_en; the final word is in memory before core's first fetch.
- reset_ low in any state returns to IDLE next edge; a partial load is abandoned, core_reset_ = 0.
- Sender may hold in_valid/in_data across in_ready low; no byte is lost or duplicated.

## Structure
- Shared package: loader state enum, BYTES_PER_WORD = 4, default ADDR_WIDTH.
- One sub-module: byte_packer (byte index counter plus 32-bit lane register, outputs word_full).
- FSM, address counter and outputs stay in imem_loader.

## Test plan
- Reset then start, 8 bytes 13 00 00 00 / 93 00 50 00 (last on 8th), no stalls -> writes 0x00000013 @0, 0x00500093 @1; done = 1, words_loaded = 2, core_reset_ = 1 one cycle after second wr_en.
- Same stream with in_valid dropped randomly -> identical writes and final state; in_ready = 0 in each WRITE cycle.
- in_last on 6th byte -> one write @0 only, error = 1, core_reset_ = 0, in_ready = 0; start -> COLLECT, error = 0.
- 256 bytes without in_last (ADDR_WIDTH = 6) -> 64 writes @0..63, then error = 1, words_loaded = 64.
- Completed load, then start -> core_reset_ and done fall same cycle; new 4-byte program AA BB CC DD (last) -> writes 0xDDCCBBAA @0.
- reset_ low for one cycle after 2 bytes of a load -> IDLE, no wr_en, all outputs 0; start begins at byte index 0, wr_addr 0.
